dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory slave answering the MEM stage's dmem_* interface: byte-enabled RAM plus a small
//  MMIO timer block (mtime/mtimecmp/scratch). Combinational read data, synchronous writes,
//  registered timer interrupt, and misalignment/access fault reporting. Sits beside the core top.
// PARAMETERS
//  RAM_BASE       32'h0000_0000  byte base address of RAM (aligned to RAM size)
//  RAM_WORDS_LOG2 10             log2 of RAM depth in 32-bit words (default 4 KiB)
//  MMIO_BASE      32'h1000_0000  base of the 32-byte MMIO window
// PORTS
//  clk              in   1   clock
//  reset            in   1   async, active-high
//  dmem_addr        in   32  byte address
//  dmem_wdata       in   32  store data, unshifted (value in low bits)
//  dmem_rdata       out  32  aligned word containing the address (combinational)
//  dmem_read        in   1   load request this cycle
//  dmem_write       in   1   store request this cycle
//  dmem_byte_enable in   4   lane mask: 0001/0010/0100/1000 byte, 0011/1100 half, 1111 word
//  timer_irq        out  1   registered (mtime >= mtimecmp)
//  fault_valid      out  1   one-cycle pulse, cycle after a faulting access
//  fault_cause      out  2   01 misaligned, 10 access fault; held until next fault
//  fault_addr       out  32  dmem_addr of last faulting access; held
// BEHAVIOUR
//  Reset: dmem_rdata driven per rules below; timer_irq=0, fault_valid=0, fault_cause=0,
//   fault_addr=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, scratch=0. RAM array is NOT reset.
//  Width decoded from byte_enable popcount (1=byte, 2=half, 4=word); other masks with a request
//   -> misaligned fault. byte_enable=0000 with request -> no-op, no fault.
//  Misaligned: half with addr[0]=1, word with addr[1:0]!=0. Access fault: addr outside RAM and
//   MMIO window, or read and write both asserted. Misaligned takes precedence over access.
//  Faulting access: no state change, dmem_rdata=0, fault_valid=1 next cycle, cause/addr latched.
//  Write lane steering: byte -> wdata[7:0] into lane addr[1:0]; half -> wdata[15:0] into lanes
//   {addr[1],0}; word -> as is. Only enabled lanes update, at posedge clk.
//  Read: dmem_read=1 -> full aligned word at {addr[31:2],2'b00}, same cycle, no lane extraction.
//   dmem_read=0 -> dmem_rdata=0. Store to word X in cycle N is visible on a read in cycle N+1
//   (no same-cycle bypass needed: read and write never both valid without fault).
//  MMIO map (offset from MMIO_BASE): 0x00 mtime_lo RO, 0x04 mtime_hi RO, 0x08 mtimecmp_lo RW,
//   0x0C mtimecmp_hi RW, 0x10 scratch RW; 0x14-0x1C read 0. Writes to RO/unmapped offsets are
//   ignored without fault. MMIO writes honour byte lanes as RAM.
//  mtime: 64-bit, +1 every clk, wraps 2^64-1 -> 0. mtimecmp write at edge N effective from N+1.
//  timer_irq <= (mtime >= mtimecmp), unsigned 64-bit, evaluated on pre-edge values.
//  Reset mid-access: pending write discarded, fault pulse cleared; RAM keeps prior contents.
// TESTING
//  sw 0x11223344 @0x10 (be 1111), lw @0x10 next cycle -> rdata 0x11223344, no fault
//  sb wdata 0x000000AB @0x13 (be 1000), lw @0x10 -> 0xAB223344
//  sh wdata 0x0000BEEF @0x12 (be 1100), lw @0x10 -> 0xBEEF3344; lb @0x11 -> rdata 0xBEEF3344
//  lw @0x11 -> rdata 0, next cycle fault_valid=1 cause 01 addr 0x11; sw @0x12 leaves word unchanged
//  access @0x2000_0000 -> rdata 0, fault cause 10; read+write same cycle -> cause 10, no write
//  after reset write mtimecmp_lo=20, mtimecmp_hi=0 -> timer_irq rises on edge after mtime==20

Source files
------------

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - dmem_* request/response bundle between the MEM stage and the data memory
interface dmem_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        read;
  logic        write;
  logic [3:0]  byte_enable;

  modport master (output addr, wdata, read, write, byte_enable, input rdata);
  modport slave  (input addr, wdata, read, write, byte_enable, output rdata);
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-enabled data RAM plus mtime/mtimecmp/scratch MMIO with fault reporting
module dmem_responder #(
  parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
  parameter int          RAM_WORDS_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE      = 32'h1000_0000
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave dmem,
  output logic            timer_irq,
  output logic            fault_valid,
  output logic [1:0]      fault_cause,
  output logic [31:0]     fault_addr
);
  localparam int RAM_WORDS = 1 << RAM_WORDS_LOG2;
  localparam int RAM_MSB   = RAM_WORDS_LOG2 + 1;

  logic [31:0] ram [RAM_WORDS];
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] scratch;

  logic        be_byte, be_half, be_word;
  logic        req, misaligned, in_ram, in_mmio, access_fault, fault;
  logic        do_read, do_write, mmio_write;
  logic [1:0]  cause;
  logic [3:0]  lane_mask, wr_lanes;
  logic [31:0] steered_wdata, mmio_rdata;
  logic [RAM_WORDS_LOG2-1:0] word_idx;
  logic [2:0]  mmio_reg;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++)
      if (lanes[i]) result[8*i +: 8] = new_word[8*i +: 8];
    return result;
  endfunction

  always_comb begin
    be_byte = 1'b0;
    be_half = 1'b0;
    be_word = 1'b0;
    case (dmem.byte_enable)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: be_byte = 1'b1;
      4'b0011, 4'b1100:                   be_half = 1'b1;
      4'b1111:                            be_word = 1'b1;
      default: ;
    endcase
  end

  // An all-zero lane mask is a no-op even if read and write are both set.
  assign req        = (dmem.read | dmem.write) & (|dmem.byte_enable);
  assign misaligned = req & (~(be_byte | be_half | be_word)
                             | (be_half & dmem.addr[0])
                             | (be_word & (|dmem.addr[1:0])));
  assign in_ram     = dmem.addr[31:RAM_MSB+1] == RAM_BASE[31:RAM_MSB+1];
  assign in_mmio    = dmem.addr[31:5] == MMIO_BASE[31:5];
  assign access_fault = req & ~misaligned
                        & (~(in_ram | in_mmio) | (dmem.read & dmem.write));
  assign fault      = misaligned | access_fault;
  assign cause      = misaligned ? 2'b01 : 2'b10;

  assign do_read    = req & dmem.read & ~fault;
  assign do_write   = req & dmem.write & ~fault;
  assign mmio_write = do_write & ~in_ram;
  assign word_idx   = dmem.addr[RAM_MSB:2];
  assign mmio_reg   = dmem.addr[4:2];

  always_comb begin
    lane_mask     = 4'b1111;
    steered_wdata = dmem.wdata;
    if (be_byte) begin
      lane_mask     = 4'b0001 << dmem.addr[1:0];
      steered_wdata = {4{dmem.wdata[7:0]}};
    end else if (be_half) begin
      lane_mask     = dmem.addr[1] ? 4'b1100 : 4'b0011;
      steered_wdata = {2{dmem.wdata[15:0]}};
    end
  end

  assign wr_lanes = lane_mask & dmem.byte_enable;

  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_reg)
      3'd0: mmio_rdata = mtime[31:0];
      3'd1: mmio_rdata = mtime[63:32];
      3'd2: mmio_rdata = mtimecmp[31:0];
      3'd3: mmio_rdata = mtimecmp[63:32];
      3'd4: mmio_rdata = scratch;
      default: ;
    endcase
  end

  assign dmem.rdata = !do_read ? 32'h0 : (in_ram ? ram[word_idx] : mmio_rdata);

  // RAM contents survive reset; only the write strobe is suppressed while it is held.
  always_ff @(posedge clk) begin
    if (!reset && do_write && in_ram)
      ram[word_idx] <= merge_lanes(ram[word_idx], steered_wdata, wr_lanes);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime       <= 64'h0;
      mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
      scratch     <= 32'h0;
      timer_irq   <= 1'b0;
      fault_valid <= 1'b0;
      fault_cause <= 2'b00;
      fault_addr  <= 32'h0;
    end else begin
      mtime       <= mtime + 64'd1;
      timer_irq   <= mtime >= mtimecmp;
      fault_valid <= fault;
      if (fault) begin
        fault_cause <= cause;
        fault_addr  <= dmem.addr;
      end
      if (mmio_write) begin
        case (mmio_reg)
          3'd2: mtimecmp[31:0]  <= merge_lanes(mtimecmp[31:0], steered_wdata, wr_lanes);
          3'd3: mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], steered_wdata, wr_lanes);
          3'd4: scratch         <= merge_lanes(scratch, steered_wdata, wr_lanes);
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder against a byte-addressed reference model
module tb_dmem_responder;
  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] RAM_BYTES = 32'd4096;
  localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        timer_irq, fault_valid;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  int          total = 0;
  int          bad = 0;

  dmem_responder_if dmem ();

  dmem_responder #(.RAM_BASE(RAM_BASE), .RAM_WORDS_LOG2(10), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk), .reset(reset), .dmem(dmem), .timer_irq(timer_irq),
    .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  // Reference model: RAM as individual bytes, MMIO as plain registers.
  logic [7:0]  m_ram [4096];
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_scratch, m_fa;
  logic        m_irq, m_fv;
  logic [1:0]  m_fc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_in_ram(input logic [31:0] a);
    logic [31:0] o;
    o = a - RAM_BASE;
    return o < RAM_BYTES;
  endfunction

  function automatic bit m_in_mmio(input logic [31:0] a);
    logic [31:0] o;
    o = a - MMIO_BASE;
    return o < 32'd32;
  endfunction

  function automatic int access_size(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1;
      4'b0011, 4'b1100:                   return 2;
      4'b1111:                            return 4;
      default:                            return 0;
    endcase
  endfunction

  function automatic logic [1:0] classify(input logic [31:0] a, input logic [3:0] be,
                                          input logic rd, input logic wr);
    int sz;
    if (be == 4'b0000 || !(rd || wr)) return 2'b00;
    sz = access_size(be);
    if (sz == 0 || (a % sz) != 0) return 2'b01;
    if (!(m_in_ram(a) || m_in_mmio(a)) || (rd && wr)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [31:0] o;
    if (m_in_ram(a)) begin
      o = a - RAM_BASE;
      return {m_ram[o+3], m_ram[o+2], m_ram[o+1], m_ram[o]};
    end
    o = a - MMIO_BASE;
    case (o)
      32'd0:  return m_mtime[31:0];
      32'd4:  return m_mtime[63:32];
      32'd8:  return m_cmp[31:0];
      32'd12: return m_cmp[63:32];
      32'd16: return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_store_byte(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] o;
    if (m_in_ram(a)) begin
      o = a - RAM_BASE;
      m_ram[o] = b;
    end else begin
      o = a - MMIO_BASE;
      case (o[4:2])
        3'd2: m_cmp[8*o[1:0] +: 8]      = b;
        3'd3: m_cmp[32+8*o[1:0] +: 8]   = b;
        3'd4: m_scratch[8*o[1:0] +: 8]  = b;
        default: ;
      endcase
    end
  endtask

  task automatic m_reset();
    m_mtime = 64'h0; m_cmp = '1; m_scratch = 32'h0;
    m_irq = 1'b0; m_fv = 1'b0; m_fc = 2'b00; m_fa = 32'h0;
  endtask

  // Compare against the model mid-cycle, then advance the model over the coming edge.
  always @(negedge clk) begin
    logic [1:0]  c;
    logic [31:0] exp_rd;
    logic        nirq;
    int          sz;
    if (reset) begin
      m_reset();
      check("rst_irq", {31'h0, timer_irq}, 32'h0);
      check("rst_fv", {31'h0, fault_valid}, 32'h0);
      check("rst_fc", {30'h0, fault_cause}, 32'h0);
      check("rst_fa", fault_addr, 32'h0);
    end else begin
      c = classify(dmem.addr, dmem.byte_enable, dmem.read, dmem.write);
      exp_rd = (c == 2'b00 && dmem.read && dmem.byte_enable != 4'b0)
               ? m_word({dmem.addr[31:2], 2'b00}) : 32'h0;
      check("rdata", dmem.rdata, exp_rd);
      check("irq", {31'h0, timer_irq}, {31'h0, m_irq});
      check("fv", {31'h0, fault_valid}, {31'h0, m_fv});
      check("fc", {30'h0, fault_cause}, {30'h0, m_fc});
      check("fa", fault_addr, m_fa);
      nirq = m_mtime >= m_cmp;
      sz = access_size(dmem.byte_enable);
      if (c == 2'b00 && dmem.write && dmem.byte_enable != 4'b0)
        for (int i = 0; i < sz; i++)
          m_store_byte(dmem.addr + i, dmem.wdata[8*i +: 8]);
      m_mtime = m_mtime + 64'd1;
      m_irq = nirq;
      m_fv = (c != 2'b00);
      if (c != 2'b00) begin
        m_fc = c;
        m_fa = dmem.addr;
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic rd,
                       input logic wr, input logic [3:0] be);
    @(posedge clk);
    #1;
    dmem.addr = a; dmem.wdata = d; dmem.read = rd; dmem.write = wr; dmem.byte_enable = be;
  endtask

  initial begin
    reset = 1'b1;
    dmem.addr = 32'h0; dmem.wdata = 32'h0; dmem.read = 1'b0; dmem.write = 1'b0;
    dmem.byte_enable = 4'b0;
    for (int i = 0; i < 4096; i++) m_ram[i] = 8'h0;
    m_reset();
    @(negedge clk);
    check("lit_rst_cause", {30'h0, fault_cause}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    drive(32'h10, 32'h1122_3344, 0, 1, 4'b1111);
    drive(32'h10, 32'h0, 1, 0, 4'b1111);
    @(negedge clk) check("lit_sw_lw", dmem.rdata, 32'h1122_3344);
    drive(32'h13, 32'h0000_00AB, 0, 1, 4'b1000);
    drive(32'h10, 32'h0, 1, 0, 4'b1111);
    @(negedge clk) check("lit_sb", dmem.rdata, 32'hAB22_3344);
    drive(32'h12, 32'h0000_BEEF, 0, 1, 4'b1100);
    drive(32'h10, 32'h0, 1, 0, 4'b1111);
    @(negedge clk) check("lit_sh", dmem.rdata, 32'hBEEF_3344);
    drive(32'h11, 32'h0, 1, 0, 4'b0010);
    @(negedge clk) check("lit_lb", dmem.rdata, 32'hBEEF_3344);
    drive(32'h11, 32'h0, 1, 0, 4'b1111);
    @(negedge clk) check("lit_misal_rd", dmem.rdata, 32'h0);
    drive(32'h12, 32'h5566_7788, 0, 1, 4'b1111);
    @(negedge clk);
    check("lit_misal_fv", {31'h0, fault_valid}, 32'h1);
    check("lit_misal_fc", {30'h0, fault_cause}, 32'h1);
    check("lit_misal_fa", fault_addr, 32'h11);
    drive(32'h10, 32'h0, 1, 0, 4'b1111);
    @(negedge clk) check("lit_misal_nowr", dmem.rdata, 32'hBEEF_3344);
    drive(32'h2000_0000, 32'h0, 1, 0, 4'b1111);
    @(negedge clk) check("lit_acc_rd", dmem.rdata, 32'h0);
    drive(32'h10, 32'h0, 1, 1, 4'b1111);
    @(negedge clk);
    check("lit_acc_fc", {30'h0, fault_cause}, 32'h2);
    check("lit_acc_fa", fault_addr, 32'h2000_0000);
    drive(32'h10, 32'h0, 1, 0, 4'b1111);
    @(negedge clk) check("lit_rw_nowr", dmem.rdata, 32'hBEEF_3344);

    drive(MMIO_BASE + 32'h10, 32'hCAFE_F00D, 0, 1, 4'b1111);
    drive(MMIO_BASE + 32'h11, 32'h0000_005A, 0, 1, 4'b0010);
    drive(MMIO_BASE + 32'h10, 32'h0, 1, 0, 4'b1111);
    @(negedge clk) check("lit_scratch", dmem.rdata, 32'hCAFE_5A0D);
    drive(MMIO_BASE, 32'hFFFF_FFFF, 0, 1, 4'b1111);
    drive(MMIO_BASE + 32'h14, 32'h0, 1, 0, 4'b1111);
    drive(32'h10, 32'h1234_5678, 0, 1, 4'b0110);
    drive(32'h10, 32'h0, 1, 0, 4'b1111);
    drive(32'h10, 32'h0000_0099, 1, 1, 4'b0000);
    drive(32'h0, 32'h0, 0, 0, 4'b0000);
    @(negedge clk) check("lit_be0_nofault", {31'h0, fault_valid}, 32'h0);

    // Reset lands on a pending store with a fault pulse in flight.
    drive(32'h2000_0000, 32'h0, 1, 0, 4'b1111);
    @(posedge clk);
    #1;
    dmem.addr = 32'h10; dmem.wdata = 32'hDEAD_BEEF; dmem.read = 1'b0; dmem.write = 1'b1;
    dmem.byte_enable = 4'b1111; reset = 1'b1;
    @(negedge clk) check("lit_rst_fv", {31'h0, fault_valid}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    dmem.write = 1'b0; dmem.byte_enable = 4'b0;

    drive(MMIO_BASE + 32'h8, 32'd20, 0, 1, 4'b1111);
    drive(MMIO_BASE + 32'hC, 32'd0, 0, 1, 4'b1111);
    drive(MMIO_BASE, 32'h0, 1, 0, 4'b1111);
    @(negedge clk) check("lit_mtime3", dmem.rdata, 32'd3);
    repeat (17) @(posedge clk);
    @(negedge clk) check("lit_irq_low", {31'h0, timer_irq}, 32'h0);
    @(posedge clk);
    @(negedge clk) check("lit_irq_high", {31'h0, timer_irq}, 32'h1);
    drive(MMIO_BASE + 32'h8, 32'h0, 1, 0, 4'b1111);
    @(negedge clk) check("lit_cmp_lo", dmem.rdata, 32'd20);
    drive(32'h10, 32'h0, 1, 0, 4'b1111);
    @(negedge clk) check("lit_ram_kept", dmem.rdata, 32'hBEEF_3344);
    drive(32'h0, 32'h0, 0, 0, 4'b0000);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
